pipeline_wb_stage5: RTL

Write-back stage of the 5-stage RV64 pipeline: the write side of the register-file path whose read side is the IDR stage. Latches MEM-stage results, extracts and sign/zero-extends load data, selects the write-back source, and drives the register-file write port. The same registered outputs feed the forwarding unit, so IDR can pick up a value in flight. An optional retired-instruction counter is included.

---
 rtl/pipeline_wb_stage5.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipeline_wb_stage5.sv
// Write-back stage of the 5-stage RV64 pipeline: load extraction, source select, RF write port / forwarding.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module pipeline_wb_stage5 #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_MEM,
  input  logic [XLEN-1:0] pc_MEM,
  input  logic [4:0]      rd_MEM,
  input  logic            rf_wr_en_MEM,
  input  logic [1:0]      rf_wr_sel_MEM,
  input  logic [2:0]      dm_rd_ctrl_MEM,
  input  logic [XLEN-1:0] alu_result_MEM,
  input  logic [XLEN-1:0] imm_MEM,
  input  logic [XLEN-1:0] dm_rdata_MEM,
  output logic            valid_WB,
  output logic [XLEN-1:0] pc_WB,
  output logic            rf_wr_en_WB,
  output logic [4:0]      rd_WB,
  output logic [XLEN-1:0] rf_wr_data_WB
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [XLEN-1:0] retire_cnt
`endif
);

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LBU  = 3'd2;
  localparam logic [2:0] LD_LH   = 3'd3;
  localparam logic [2:0] LD_LHU  = 3'd4;
  localparam logic [2:0] LD_LW   = 3'd5;
  localparam logic [2:0] LD_LWU  = 3'd6;
  localparam logic [2:0] LD_LD   = 3'd7;

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_PC4 = 2'b01;
  localparam logic [1:0] SEL_LD  = 2'b10;
  localparam logic [1:0] SEL_IMM = 2'b11;

  // Alignment is forced by dropping the low address bits; misalignment is not flagged.
  function automatic logic [XLEN-1:0] extract_load(input logic [2:0]      ctrl,
                                                   input logic [2:0]      addr,
                                                   input logic [XLEN-1:0] dword);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic [XLEN-1:0]    res;
    b = dword[{addr, 3'b000} +: 8];
    h = dword[{addr[2:1], 4'b0000} +: 16];
    w = dword[{addr[2], 5'b00000} +: 32];
    case (ctrl)
      LD_LB:   res = XLEN'(b);
      LD_LBU:  res = XLEN'($unsigned(b));
      LD_LH:   res = XLEN'(h);
      LD_LHU:  res = XLEN'($unsigned(h));
      LD_LW:   res = XLEN'(w);
      LD_LWU:  res = XLEN'($unsigned(w));
      LD_LD:   res = dword;
      LD_NONE: res = '0;
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [XLEN-1:0] select_wdata(input logic [1:0]      sel,
                                                   input logic [XLEN-1:0] alu,
                                                   input logic [XLEN-1:0] pc,
                                                   input logic [XLEN-1:0] load,
                                                   input logic [XLEN-1:0] imm);
    logic [XLEN-1:0] res;
    case (sel)
      SEL_ALU: res = alu;
      SEL_PC4: res = pc + XLEN'(4);
      SEL_LD:  res = load;
      SEL_IMM: res = imm;
      default: res = alu;
    endcase
    return res;
  endfunction

  logic [XLEN-1:0] load_data_p0;
  logic [XLEN-1:0] wr_data_p0;
  logic            wr_en_p0;
  logic            capture;

  assign load_data_p0 = extract_load(dm_rd_ctrl_MEM, alu_result_MEM[2:0], dm_rdata_MEM);
  assign wr_data_p0   = select_wdata(rf_wr_sel_MEM, alu_result_MEM, pc_MEM, load_data_p0, imm_MEM);
  assign wr_en_p0     = rf_wr_en_MEM & valid_MEM & (rd_MEM != 5'd0);
  assign capture      = !flush && !stall;

  // MEM -> WB register boundary
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid_WB      <= 1'b0;
      pc_WB         <= '0;
      rf_wr_en_WB   <= 1'b0;
      rd_WB         <= '0;
      rf_wr_data_WB <= '0;
    end else if (!stall) begin
      valid_WB      <= valid_MEM;
      pc_WB         <= pc_MEM;
      rf_wr_en_WB   <= wr_en_p0;
      rd_WB         <= rd_MEM;
      rf_wr_data_WB <= wr_data_p0;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [XLEN-1:0] retire_cnt_q;

  // Counts only edges that actually capture a real instruction; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else if (capture && valid_MEM) begin
      retire_cnt_q <= retire_cnt_q + XLEN'(1);
    end
  end

  assign retire_cnt = retire_cnt_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule
